// File: rtl/bp_resolve_queue_pkg.sv
// Shared types for the branch-predictor resolve queue: stored record, training update
// and default sizing.
package bp_resolve_queue_pkg;

    localparam int unsigned VLEN             = 32;
    localparam int unsigned BP_META_W        = 10;
    localparam int unsigned BP_RESOLVE_DEPTH = 8;

    typedef logic [BP_META_W-1:0] bp_metadata_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
        bp_metadata_t    metadata;
    } bht_update_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
        bp_metadata_t    metadata;
    } bp_resolve_rec_t;

endpackage

// File: rtl/bp_resolve_queue.sv
// Holds predicted conditional branches until execute resolves them in order; emits the
// registered predictor training update and flags mispredicts / desyncs.
module bp_resolve_queue
    import bp_resolve_queue_pkg::*;
#(
    parameter int unsigned DEPTH = BP_RESOLVE_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [VLEN-1:0]          push_pc_i,
    input  logic                     push_taken_i,
    input  bp_metadata_t             push_metadata_i,
    input  logic                     resolve_valid_i,
    input  logic [VLEN-1:0]          resolve_pc_i,
    input  logic                     resolve_taken_i,
    output bht_update_t              bht_update_o,
    output logic                     mispredict_o,
    output logic                     desync_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    bp_resolve_rec_t mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    bht_update_t     update_q;
    logic            mispredict_q, desync_q;

    bp_resolve_rec_t head;
    logic            full, empty, hit, mispredict, clear, push_fire;

    always_comb begin
        head       = mem_q[rd_ptr_q];
        full       = (count_q == CntW'(DEPTH));
        empty      = (count_q == '0);
        hit        = resolve_valid_i && !empty && (resolve_pc_i == head.pc);
        mispredict = hit && (resolve_taken_i != head.taken);
        // Any of these empties the queue and drops a same-cycle push.
        clear      = flush_i || mispredict || (resolve_valid_i && !hit);
        push_fire  = push_valid_i && !full && !clear;
    end

    assign push_ready_o = !full;
    assign count_o      = count_q;
    assign bht_update_o = update_q;
    assign mispredict_o = mispredict_q;
    assign desync_o     = desync_q;

    // Slot storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc_i, taken: push_taken_i, metadata: push_metadata_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            update_q     <= '0;
            mispredict_q <= 1'b0;
            desync_q     <= 1'b0;
        end else begin
            if (clear) begin
                rd_ptr_q <= wr_ptr_q;
                count_q  <= '0;
            end else begin
                if (hit)       rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q <= count_q + CntW'(push_fire) - CntW'(hit);
            end

            if (hit) begin
                update_q <= '{valid:    !debug_mode_i,
                              pc:       head.pc,
                              taken:    resolve_taken_i,
                              metadata: head.metadata};
            end else begin
                update_q <= '0;
            end
            mispredict_q <= mispredict;
            desync_q     <= resolve_valid_i && !hit;
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Randomised and directed bench for bp_resolve_queue with a queue-based reference model
// and a scoreboard monitor for the registered output pulses.
module tb_bp_resolve_queue;
    import bp_resolve_queue_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              flush_i = 1'b0, debug_mode_i = 1'b0;
    logic              push_valid_i = 1'b0, push_taken_i = 1'b0;
    logic [VLEN-1:0]   push_pc_i = '0;
    bp_metadata_t      push_metadata_i = '0;
    logic              resolve_valid_i = 1'b0, resolve_taken_i = 1'b0;
    logic [VLEN-1:0]   resolve_pc_i = '0;
    logic              push_ready_o, mispredict_o, desync_o;
    bht_update_t       bht_update_o;
    logic [3:0]        count_o;

    bp_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .debug_mode_i    (debug_mode_i),
        .push_valid_i    (push_valid_i),
        .push_ready_o    (push_ready_o),
        .push_pc_i       (push_pc_i),
        .push_taken_i    (push_taken_i),
        .push_metadata_i (push_metadata_i),
        .resolve_valid_i (resolve_valid_i),
        .resolve_pc_i    (resolve_pc_i),
        .resolve_taken_i (resolve_taken_i),
        .bht_update_o    (bht_update_o),
        .mispredict_o    (mispredict_o),
        .desync_o        (desync_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic            upd_v;
        logic [VLEN-1:0] pc;
        logic            taken;
        bp_metadata_t    meta;
        logic            mis;
        logic            des;
        int              at;
    } exp_t;

    bp_resolve_rec_t mq[$];   // reference: records in program order
    exp_t            eq[$];   // expected visible output pulses
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        push_valid_i    = 1'b0;
        resolve_valid_i = 1'b0;
        flush_i         = 1'b0;
        debug_mode_i    = 1'b0;
    endtask

    // One cycle: check occupancy, apply inputs, advance the reference model.
    task automatic step(input bit pv, input logic [VLEN-1:0] ppc, input bit pt,
                        input bp_metadata_t pm, input bit rv, input logic [VLEN-1:0] rpc,
                        input bit rt, input bit fl, input bit dbg);
        bit   full, hit, mis;
        exp_t e;
        @(negedge clk_i);
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("push_ready", 64'(push_ready_o), 64'(mq.size() < DEPTH));
        push_valid_i = pv; push_pc_i = ppc; push_taken_i = pt; push_metadata_i = pm;
        resolve_valid_i = rv; resolve_pc_i = rpc; resolve_taken_i = rt;
        flush_i = fl; debug_mode_i = dbg;

        full = (mq.size() == DEPTH);
        hit  = rv && mq.size() > 0 && mq[0].pc == rpc;
        mis  = hit && (rt != mq[0].taken);
        if (rv) begin
            e.at = cyc + 1;
            if (hit) begin
                e.upd_v = !dbg; e.pc = mq[0].pc; e.taken = rt; e.meta = mq[0].metadata;
                e.mis = mis; e.des = 1'b0;
                void'(mq.pop_front());
            end else begin
                e.upd_v = 1'b0; e.pc = '0; e.taken = 1'b0; e.meta = '0;
                e.mis = 1'b0; e.des = 1'b1;
            end
            if (e.upd_v || e.mis || e.des) eq.push_back(e);
        end
        if (fl || mis || (rv && !hit)) mq.delete();
        else if (pv && !full) mq.push_back('{pc: ppc, taken: pt, metadata: pm});
    endtask

    task automatic idle();
        step(0, '0, 0, '0, 0, '0, 0, 0, 0);
    endtask

    task automatic push(input logic [VLEN-1:0] pc, input bit t, input bp_metadata_t m);
        step(1, pc, t, m, 0, '0, 0, 0, 0);
    endtask

    function automatic logic [VLEN-1:0] head_pc();
        return (mq.size() > 0) ? mq[0].pc : '0;
    endfunction

    function automatic bit head_taken();
        return (mq.size() > 0) ? mq[0].taken : 1'b0;
    endfunction

    // Scoreboard monitor: consumes one expectation per visible output pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_ni && (bht_update_o.valid || mispredict_o || desync_o)) begin
                if (eq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: got valid=%0b mis=%0b desync=%0b expected none",
                             bht_update_o.valid, mispredict_o, desync_o);
                end else begin
                    e = eq.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.at));
                    chk("upd_valid", 64'(bht_update_o.valid), 64'(e.upd_v));
                    if (e.upd_v) begin
                        chk("upd_pc", 64'(bht_update_o.pc), 64'(e.pc));
                        chk("upd_taken", 64'(bht_update_o.taken), 64'(e.taken));
                        chk("upd_meta", 64'(bht_update_o.metadata), 64'(e.meta));
                    end
                    chk("mispredict", 64'(mispredict_o), 64'(e.mis));
                    chk("desync", 64'(desync_o), 64'(e.des));
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_update", 64'(bht_update_o), 64'(0));
        chk("rst_mis", 64'(mispredict_o), 64'(0));
        chk("rst_desync", 64'(desync_o), 64'(0));
        chk("rst_count", 64'(count_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Two in-order correct resolves
        push(32'h100, 1, 10'd1);
        push(32'h104, 0, 10'd2);
        step(0, '0, 0, '0, 1, 32'h100, 1, 0, 0);
        step(0, '0, 0, '0, 1, 32'h104, 0, 0, 0);
        idle(); idle();

        // Mispredict squashes younger entries and a same-cycle push
        push(32'h300, 1, 10'd3); push(32'h304, 1, 10'd4); push(32'h308, 0, 10'd5);
        step(1, 32'h30c, 1, 10'd6, 1, 32'h300, 0, 0, 0);
        idle(); idle();

        // Fill, pop+push while full, then wrap with push/pop pairs
        for (int i = 0; i < DEPTH; i++) push(32'h400 + 32'(i * 4), i[0], bp_metadata_t'(i));
        step(1, 32'h500, 1, 10'd9, 1, head_pc(), head_taken(), 0, 0);
        for (int i = 0; i < 20; i++)
            step(1, 32'h600 + 32'(i * 4), i[1], bp_metadata_t'(i + 32), 1, head_pc(),
                 head_taken(), 0, 0);
        while (mq.size() > 0) step(0, '0, 0, '0, 1, head_pc(), head_taken(), 0, 0);
        idle();

        // Desync: empty queue, then head pc mismatch
        step(0, '0, 0, '0, 1, 32'h700, 1, 0, 0);
        push(32'h200, 1, 10'd7);
        step(0, '0, 0, '0, 1, 32'h204, 1, 0, 0);
        idle(); idle();

        // Flush with same-cycle head resolve still emits its update
        for (int i = 0; i < 4; i++) push(32'h800 + 32'(i * 4), 1, bp_metadata_t'(i + 64));
        step(1, 32'h900, 0, 10'd1, 1, 32'h800, 1, 1, 0);
        idle(); idle();

        // Debug mode: pop occurs, update suppressed; mispredict still reported
        push(32'ha00, 1, 10'd11); push(32'ha04, 0, 10'd12);
        step(0, '0, 0, '0, 1, 32'ha00, 1, 0, 1);
        step(0, '0, 0, '0, 1, 32'ha04, 1, 0, 1);
        idle(); idle();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit rv, rt;
            logic [VLEN-1:0] rpc;
            rv  = (mq.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
            rpc = (mq.size() > 0 && $urandom % 12 != 0) ? mq[0].pc
                  : VLEN'($urandom_range(0, 63)) << 2;
            rt  = (mq.size() > 0 && $urandom % 6 != 0) ? mq[0].taken : 1'($urandom);
            step($urandom % 4 != 0, VLEN'($urandom_range(0, 63)) << 2, 1'($urandom),
                 bp_metadata_t'($urandom), rv, rpc, rt, $urandom % 50 == 0, $urandom % 8 == 0);
        end
        idle(); idle();

        // Asynchronous reset right after an update becomes visible
        push(32'hb00, 1, 10'd13); push(32'hb04, 1, 10'd14);
        step(0, '0, 0, '0, 1, 32'hb00, 1, 0, 0);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        drive_idle();
        #1;
        chk("async_rst_update", 64'(bht_update_o), 64'(0));
        chk("async_rst_mis", 64'(mispredict_o), 64'(0));
        chk("async_rst_count", 64'(count_o), 64'(0));
        chk("async_rst_ready", 64'(push_ready_o), 64'(1));
        mq.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        push(32'hc00, 0, 10'd15);
        step(0, '0, 0, '0, 1, 32'hc00, 0, 0, 0);
        idle(); idle(); idle();

        chk("pending_expectations", 64'(eq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
